// File: rtl/write_queue.sv
// Wide-to-narrow width converter: each accepted IN_WIDTH word is replayed as
// IN_WIDTH/OUT_WIDTH beats on a valid/ready stream, least-significant slice first.
module write_queue #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic                 vld_in,
    output logic                 rdy_upward,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 vld_out,
    input  logic                 rdy_downward,
    output logic                 last_out
);

    localparam int MAX   = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = $clog2(MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t                 state_reg;
    logic [IN_WIDTH-1:0]    dtmp_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   vld_out_reg;
    logic                   last_out_reg;

    // last_out_reg mirrors (state==SEND && cnt==MAX-1), so upstream is only
    // offered the slot while the final beat is being consumed.
    assign rdy_upward = reset & ((state_reg == EMPTY) | (last_out_reg & rdy_downward));
    assign vld_out    = vld_out_reg;
    assign last_out   = last_out_reg;
    assign dout       = dtmp_reg[OUT_WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= EMPTY;
            dtmp_reg     <= '0;
            cnt_reg      <= '0;
            vld_out_reg  <= 1'b0;
            last_out_reg <= 1'b0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (vld_in) begin
                        dtmp_reg     <= din;
                        cnt_reg      <= '0;
                        state_reg    <= SEND;
                        vld_out_reg  <= 1'b1;
                        last_out_reg <= 1'b0;
                    end
                end
                SEND: begin
                    if (rdy_downward) begin
                        if (cnt_reg == CNT_LAST) begin
                            if (vld_in) begin
                                dtmp_reg     <= din;
                                cnt_reg      <= '0;
                                last_out_reg <= 1'b0;
                            end else begin
                                // Clearing dtmp keeps dout at zero while idle.
                                state_reg    <= EMPTY;
                                dtmp_reg     <= '0;
                                cnt_reg      <= '0;
                                vld_out_reg  <= 1'b0;
                                last_out_reg <= 1'b0;
                            end
                        end else begin
                            dtmp_reg     <= dtmp_reg >> OUT_WIDTH;
                            cnt_reg      <= cnt_reg + 1'b1;
                            last_out_reg <= ((cnt_reg + 1'b1) == CNT_LAST);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_write_queue.sv
// Directed bench for write_queue: MAX=2 instance for most scenarios, plus a
// MAX=4 instance (128->32) sharing clock and reset.
module tb_write_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [63:0]  din;
    logic         vld_in;
    logic         rdy_upward;
    logic [31:0]  dout;
    logic         vld_out;
    logic         rdy_downward;
    logic         last_out;

    logic [127:0] din4;
    logic         vld_in4;
    logic         rdy_upward4;
    logic [31:0]  dout4;
    logic         vld_out4;
    logic         rdy_downward4;
    logic         last_out4;

    int n_tests = 0;
    int n_fail  = 0;

    write_queue #(.IN_WIDTH(64), .OUT_WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .din(din), .vld_in(vld_in),
        .rdy_upward(rdy_upward), .dout(dout), .vld_out(vld_out),
        .rdy_downward(rdy_downward), .last_out(last_out)
    );

    write_queue #(.IN_WIDTH(128), .OUT_WIDTH(32)) u_dut4 (
        .clk(clk), .reset(reset), .din(din4), .vld_in(vld_in4),
        .rdy_upward(rdy_upward4), .dout(dout4), .vld_out(vld_out4),
        .rdy_downward(rdy_downward4), .last_out(last_out4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; din = 64'h0123_4567_89AB_CDEF; vld_in = 1'b0; rdy_downward = 1'b0;
        din4 = '0; vld_in4 = 1'b0; rdy_downward4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            vld_in = i[0]; rdy_downward = i[1]; vld_in4 = i[0];
            #1;
            n_tests++;
            if (vld_out !== 1'b0 || rdy_upward !== 1'b0 || dout !== 32'h0 || last_out !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: vld_out=%b rdy_upward=%b dout=%h last_out=%b, required 0 0 00000000 0",
                         i, vld_out, rdy_upward, dout, last_out);
            end
            n_tests++;
            if (vld_out4 !== 1'b0 || rdy_upward4 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold4[%0d]: vld_out=%b rdy_upward=%b, required 0 0", i, vld_out4, rdy_upward4);
            end
        end
        vld_in = 1'b0; rdy_downward = 1'b0; vld_in4 = 1'b0;
        step();
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (rdy_upward !== 1'b1 || vld_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: rdy_upward=%b vld_out=%b, required 1 0", rdy_upward, vld_out);
        end
        $display("[TB] reset: released, rdy_upward=%b", rdy_upward);
    endtask

    task automatic test_single();
        step();
        din = 64'h1111_2222_3333_4444; vld_in = 1'b1; rdy_downward = 1'b1;
        #1;
        n_tests++;
        if (rdy_upward !== 1'b1 || vld_out !== 1'b0) begin
            n_fail++;
            $display("FAIL single_accept: rdy_upward=%b vld_out=%b, required 1 0", rdy_upward, vld_out);
        end
        step();
        vld_in = 1'b0;
        #1;
        n_tests++;
        if (vld_out !== 1'b1 || dout !== 32'h3333_4444 || last_out !== 1'b0 || rdy_upward !== 1'b0) begin
            n_fail++;
            $display("FAIL single_beat0: vld=%b dout=%h last=%b rdy_up=%b, required 1 33334444 0 0",
                     vld_out, dout, last_out, rdy_upward);
        end
        $display("[TB] single: beat dout=%h last=%b", dout, last_out);
        step();
        #1;
        n_tests++;
        if (vld_out !== 1'b1 || dout !== 32'h1111_2222 || last_out !== 1'b1 || rdy_upward !== 1'b1) begin
            n_fail++;
            $display("FAIL single_beat1: vld=%b dout=%h last=%b rdy_up=%b, required 1 11112222 1 1",
                     vld_out, dout, last_out, rdy_upward);
        end
        $display("[TB] single: beat dout=%h last=%b", dout, last_out);
        step();
        #1;
        n_tests++;
        if (vld_out !== 1'b0 || dout !== 32'h0 || last_out !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: vld=%b dout=%h last=%b, required 0 00000000 0", vld_out, dout, last_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_beat [4];
        logic        exp_last [4];
        exp_beat = '{32'hBBBB_BBBB, 32'hAAAA_AAAA, 32'hDDDD_DDDD, 32'hCCCC_CCCC};
        exp_last = '{1'b0, 1'b1, 1'b0, 1'b1};
        step();
        din = 64'hAAAA_AAAA_BBBB_BBBB; vld_in = 1'b1; rdy_downward = 1'b1;
        step();
        din = 64'hCCCC_CCCC_DDDD_DDDD;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) vld_in = 1'b0;
            #1;
            n_tests++;
            if (vld_out !== 1'b1 || dout !== exp_beat[i] || last_out !== exp_last[i]) begin
                n_fail++;
                $display("FAIL b2b_beat[%0d]: vld=%b dout=%h last=%b, required 1 %h %b",
                         i, vld_out, dout, last_out, exp_beat[i], exp_last[i]);
            end
            $display("[TB] b2b: beat dout=%h last=%b", dout, last_out);
            if (i == 1) begin
                n_tests++;
                if (rdy_upward !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_second_accept: rdy_upward=%b, required 1", rdy_upward);
                end
            end
            step();
        end
        #1;
        n_tests++;
        if (vld_out !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: vld_out=%b, required 0", vld_out);
        end
    endtask

    task automatic test_backpressure();
        step();
        din = 64'h1111_2222_3333_4444; vld_in = 1'b1; rdy_downward = 1'b1;
        step();
        vld_in = 1'b0; rdy_downward = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (vld_out !== 1'b1 || dout !== 32'h3333_4444 || rdy_upward !== 1'b0 || last_out !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall[%0d]: vld=%b dout=%h rdy_up=%b last=%b, required 1 33334444 0 0",
                         i, vld_out, dout, rdy_upward, last_out);
            end
            step();
        end
        rdy_downward = 1'b1;
        #1;
        n_tests++;
        if (vld_out !== 1'b1 || dout !== 32'h3333_4444) begin
            n_fail++;
            $display("FAIL bp_resume0: vld=%b dout=%h, required 1 33334444", vld_out, dout);
        end
        $display("[TB] backpressure: beat dout=%h last=%b", dout, last_out);
        step();
        #1;
        n_tests++;
        if (vld_out !== 1'b1 || dout !== 32'h1111_2222 || last_out !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_resume1: vld=%b dout=%h last=%b, required 1 11112222 1", vld_out, dout, last_out);
        end
        $display("[TB] backpressure: beat dout=%h last=%b", dout, last_out);
        step();
        #1;
        n_tests++;
        if (vld_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle: vld_out=%b, required 0", vld_out);
        end
    endtask

    task automatic test_reset_mid_word();
        step();
        din = 64'h1111_2222_3333_4444; vld_in = 1'b1; rdy_downward = 1'b1;
        step();
        vld_in = 1'b0;
        step();
        #1;
        n_tests++;
        if (vld_out !== 1'b1 || dout !== 32'h1111_2222) begin
            n_fail++;
            $display("FAIL mid_pre: vld=%b dout=%h, required 1 11112222", vld_out, dout);
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if (vld_out !== 1'b0 || dout !== 32'h0 || last_out !== 1'b0 || rdy_upward !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async: vld=%b dout=%h last=%b rdy_up=%b, required 0 00000000 0 0",
                     vld_out, dout, last_out, rdy_upward);
        end
        step();
        step();
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (rdy_upward !== 1'b1 || vld_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release: rdy_up=%b vld=%b, required 1 0", rdy_upward, vld_out);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (vld_out !== 1'b0 || dout !== 32'h0) begin
                n_fail++;
                $display("FAIL mid_discard[%0d]: vld=%b dout=%h, required 0 00000000", i, vld_out, dout);
            end
        end
        din = 64'h5555_6666_7777_8888; vld_in = 1'b1;
        step();
        vld_in = 1'b0;
        #1;
        n_tests++;
        if (vld_out !== 1'b1 || dout !== 32'h7777_8888 || last_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_next0: vld=%b dout=%h last=%b, required 1 77778888 0", vld_out, dout, last_out);
        end
        $display("[TB] reset_mid: beat dout=%h last=%b", dout, last_out);
        step();
        #1;
        n_tests++;
        if (dout !== 32'h5555_6666 || last_out !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_next1: dout=%h last=%b, required 55556666 1", dout, last_out);
        end
        step();
    endtask

    task automatic test_max4();
        logic [31:0] exp_beat [4];
        exp_beat = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        step();
        din4 = 128'h4444_4444_3333_3333_2222_2222_1111_1111; vld_in4 = 1'b1; rdy_downward4 = 1'b1;
        step();
        vld_in4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (vld_out4 !== 1'b1 || dout4 !== exp_beat[i] || last_out4 !== (i == 3)) begin
                n_fail++;
                $display("FAIL max4_beat[%0d]: vld=%b dout=%h last=%b, required 1 %h %b",
                         i, vld_out4, dout4, last_out4, exp_beat[i], (i == 3));
            end
            $display("[TB] max4: beat dout=%h last=%b", dout4, last_out4);
            step();
        end
        #1;
        n_tests++;
        if (vld_out4 !== 1'b0) begin
            n_fail++;
            $display("FAIL max4_idle: vld_out=%b, required 0", vld_out4);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_max4();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
